// File: rtl/apb_periph_pkg.sv
// Shared register map and field layout for the APB peripherals
// hanging off the AHB-to-APB bridge.
package apb_periph_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_LOAD   = 3'd1;
   localparam logic [2:0] ADDR_COUNT  = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_PRE    = 3'd4;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_AUTO  = 1;
   localparam int CTRL_IRQEN = 2;
   localparam int CTRL_W     = 3;

   // Last field is bit 0, so the layout matches CTRL_EN/AUTO/IRQEN.
   typedef struct packed {
      logic irqen;
      logic auto_rl;
      logic en;
   } timer_ctrl_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_ACCESS
   } apb_phase_e;

   function automatic apb_phase_e apb_phase(
      input logic sel,
      input logic penable
   );
      if (!sel)
         return PH_IDLE;
      else if (!penable)
         return PH_SETUP;
      else
         return PH_ACCESS;
   endfunction

endpackage

// File: rtl/apb_slave_if.sv
// Zero-wait-state APB slave front end: phase decode, register index
// and a registered read-data port loaded during the setup phase.
module apb_slave_if
   import apb_periph_pkg::*;
#(
   parameter int SEL_INDEX = 0
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] rd_data_i,
   output logic        wr_en_o,
   output logic        rd_en_o,
   output logic [2:0]  reg_idx_o,
   output logic [31:0] Prdata
);

   apb_phase_e  phase;
   logic [31:0] prdata_q;
   logic        unused_bits;

   assign phase     = apb_phase(Pselx[SEL_INDEX], Penable);
   assign rd_en_o   = (phase == PH_SETUP) && !Pwrite;
   assign wr_en_o   = (phase == PH_ACCESS) && Pwrite;
   assign reg_idx_o = Paddr[4:2];
   assign unused_bits = ^{Pselx, Paddr[31:5], Paddr[1:0]};

   // Bridge samples in the access phase; capture one cycle earlier.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset)
         prdata_q <= '0;
      else if (rd_en_o)
         prdata_q <= rd_data_i;
   end

   assign Prdata = prdata_q;

endmodule

// File: rtl/apb_timer_slave.sv
// APB down-counter timer: prescaler, one-shot or auto-reload,
// sticky EXPIRED flag and a registered level interrupt.
module apb_timer_slave
   import apb_periph_pkg::*;
#(
   parameter int SEL_INDEX = 0,
   parameter int CNT_W     = 32,
   parameter int PRE_W     = 16
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Tirq
);

   logic        wr_en;
   logic        rd_en;
   logic [2:0]  reg_idx;
   logic [31:0] rd_data;

   timer_ctrl_t      ctrl_q, ctrl_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] precnt_q, precnt_d;
   logic             expired_q, expired_d;
   logic             tirq_q;

   logic wr_ctrl, wr_load, wr_status, wr_pre;
   logic en_rise, run, tick;

   apb_slave_if #(
      .SEL_INDEX(SEL_INDEX)
   ) u_if (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .rd_data_i (rd_data),
      .wr_en_o   (wr_en),
      .rd_en_o   (rd_en),
      .reg_idx_o (reg_idx),
      .Prdata    (Prdata)
   );

   always_comb begin
      wr_ctrl   = wr_en && (reg_idx == ADDR_CTRL);
      wr_load   = wr_en && (reg_idx == ADDR_LOAD);
      wr_status = wr_en && (reg_idx == ADDR_STATUS);
      wr_pre    = wr_en && (reg_idx == ADDR_PRE);
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      pre_d     = pre_q;
      count_d   = count_q;
      precnt_d  = precnt_q;
      expired_d = expired_q;

      if (wr_ctrl)
         ctrl_d = timer_ctrl_t'(Pwdata[CTRL_W-1:0]);
      if (wr_load)
         load_d = Pwdata[CNT_W-1:0];
      if (wr_pre)
         pre_d = Pwdata[PRE_W-1:0];

      en_rise = wr_ctrl && Pwdata[CTRL_EN] && !ctrl_q.en;
      // A same-cycle CTRL write that drops EN suppresses the tick.
      run  = ctrl_q.en && ctrl_d.en;
      tick = run && (precnt_q == pre_q);

      if (!run || tick)
         precnt_d = '0;
      else
         precnt_d = precnt_q + PRE_W'(1);

      if (wr_status && Pwdata[0])
         expired_d = 1'b0;

      if (en_rise) begin
         count_d = load_q;
      end else if (tick) begin
         if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            expired_d = 1'b1;
            if (ctrl_d.auto_rl)
               count_d = load_q;
            else
               ctrl_d.en = 1'b0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (reg_idx)
            ADDR_CTRL:   rd_data[CTRL_W-1:0] = ctrl_q;
            ADDR_LOAD:   rd_data[CNT_W-1:0]  = load_q;
            ADDR_COUNT:  rd_data[CNT_W-1:0]  = count_q;
            ADDR_STATUS: rd_data[0]          = expired_q;
            ADDR_PRE:    rd_data[PRE_W-1:0]  = pre_q;
            default:     rd_data             = '0;
         endcase
      end
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         pre_q     <= '0;
         count_q   <= '0;
         precnt_q  <= '0;
         expired_q <= 1'b0;
         tirq_q    <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         pre_q     <= pre_d;
         count_q   <= count_d;
         precnt_q  <= precnt_d;
         expired_q <= expired_d;
         tirq_q    <= expired_q && ctrl_q.irqen;
      end
   end

   assign Tirq = tirq_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Scoreboard bench for apb_timer_slave: reads queue their expected
// data, a negedge monitor checks Prdata in each access phase.
module tb_apb_timer_slave;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_LOAD   = 32'h04;
   localparam logic [31:0] A_COUNT  = 32'h08;
   localparam logic [31:0] A_STATUS = 32'h0C;
   localparam logic [31:0] A_PRE    = 32'h10;
   localparam logic [31:0] A_UNMAP  = 32'h1C;

   logic        Hclk = 1'b0;
   logic        Hreset = 1'b1;
   logic [2:0]  Pselx = '0;
   logic        Penable = 1'b0;
   logic        Pwrite = 1'b0;
   logic [31:0] Paddr = '0;
   logic [31:0] Pwdata = '0;
   logic [31:0] Prdata;
   logic        Tirq;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];

   always #5 Hclk = ~Hclk;

   apb_timer_slave #(
      .SEL_INDEX(0),
      .CNT_W    (32),
      .PRE_W    (16)
   ) dut (
      .Hclk    (Hclk),
      .Hreset  (Hreset),
      .Pselx   (Pselx),
      .Penable (Penable),
      .Pwrite  (Pwrite),
      .Paddr   (Paddr),
      .Pwdata  (Pwdata),
      .Prdata  (Prdata),
      .Tirq    (Tirq)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      Pselx = '0;
      Penable = 1'b0;
      Pwrite = 1'b0;
   endtask

   // Called 1 time unit after a rising edge; commits on the 2nd edge.
   task automatic apb_wr(input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] data);
      Pselx = sel;
      Paddr = addr;
      Pwdata = data;
      Pwrite = 1'b1;
      Penable = 1'b0;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      @(posedge Hclk);
      #1 idle();
   endtask

   // Prdata is captured on the 1st edge, checked before the 2nd.
   task automatic apb_rd(input string name, input logic [31:0] addr,
                         input logic [31:0] exp);
      exp_q.push_back('{name, exp});
      Pselx = 3'b001;
      Paddr = addr;
      Pwrite = 1'b0;
      Penable = 1'b0;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      @(posedge Hclk);
      #1 idle();
   endtask

   always @(negedge Hclk) begin
      exp_t e;
      if (!Hreset && Pselx[0] && Penable && !Pwrite) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_read: got 0x%08h, want none", Prdata);
         end else begin
            e = exp_q.pop_front();
            chk(e.name, Prdata, e.val);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      chk("rst_prdata", Prdata, 32'h0);
      chk("rst_tirq", {31'b0, Tirq}, 32'h0);
      Hreset = 1'b0;
      @(posedge Hclk);
      #1;
      apb_rd("rst_ctrl", A_CTRL, 32'h0);
      apb_rd("rst_load", A_LOAD, 32'h0);
      apb_rd("rst_count", A_COUNT, 32'h0);
      apb_rd("rst_status", A_STATUS, 32'h0);
      apb_rd("rst_pre", A_PRE, 32'h0);

      apb_wr(3'b001, A_LOAD, 32'h0000_0010);
      apb_wr(3'b001, A_PRE, 32'h0000_0003);
      apb_rd("rw_load", A_LOAD, 32'h10);
      apb_rd("rw_pre_hiaddr", 32'hA000_0013, 32'h3);
      apb_wr(3'b001, A_COUNT, 32'h0000_FFFF);
      apb_rd("rw_count_ro", A_COUNT, 32'h0);
      apb_wr(3'b001, A_UNMAP, 32'hDEAD_BEEF);
      apb_rd("rw_unmapped", A_UNMAP, 32'h0);
      apb_wr(3'b001, A_PRE, 32'h0001_2345);
      apb_rd("rw_pre_trunc", A_PRE, 32'h2345);
      apb_wr(3'b001, A_PRE, 32'h3);
      apb_wr(3'b001, A_LOAD, 32'hFFFF_FFFF);
      apb_rd("rw_load_full", A_LOAD, 32'hFFFF_FFFF);
      apb_wr(3'b001, A_LOAD, 32'h10);
      apb_wr(3'b001, A_CTRL, 32'hFFFF_FFF2);
      apb_rd("rw_ctrl_bits", A_CTRL, 32'h2);
      apb_wr(3'b001, A_CTRL, 32'h0);

      apb_wr(3'b010, A_LOAD, 32'h0000_ABCD);
      apb_wr(3'b010, A_PRE, 32'h7);
      apb_wr(3'b010, A_CTRL, 32'h7);
      apb_rd("othsel_load", A_LOAD, 32'h10);
      apb_rd("othsel_pre", A_PRE, 32'h3);
      apb_rd("othsel_ctrl", A_CTRL, 32'h0);
      apb_rd("othsel_count", A_COUNT, 32'h0);

      // One-shot: enable commits at E0, ticks every edge after.
      apb_wr(3'b001, A_LOAD, 32'h3);
      apb_wr(3'b001, A_PRE, 32'h0);
      apb_wr(3'b001, A_CTRL, 32'h5);
      apb_rd("os_count3", A_COUNT, 32'h3);
      apb_rd("os_count1", A_COUNT, 32'h1);
      @(negedge Hclk);
      chk("os_tirq_lag", {31'b0, Tirq}, 32'h0);
      @(negedge Hclk);
      chk("os_tirq_set", {31'b0, Tirq}, 32'h1);
      @(posedge Hclk);
      #1;
      apb_rd("os_expired", A_STATUS, 32'h1);
      apb_rd("os_en_clr", A_CTRL, 32'h4);
      apb_rd("os_count0", A_COUNT, 32'h0);

      apb_wr(3'b001, A_STATUS, 32'h1);
      @(negedge Hclk);
      chk("w1c_tirq_hold", {31'b0, Tirq}, 32'h1);
      @(negedge Hclk);
      chk("w1c_tirq_clr", {31'b0, Tirq}, 32'h0);
      @(posedge Hclk);
      #1;
      apb_rd("w1c_status", A_STATUS, 32'h0);

      // Same one-shot offset by one cycle to see the even counts.
      apb_wr(3'b001, A_CTRL, 32'h5);
      @(posedge Hclk);
      #1;
      apb_rd("os2_count2", A_COUNT, 32'h2);
      apb_rd("os2_count0", A_COUNT, 32'h0);
      apb_rd("os2_expired", A_STATUS, 32'h1);
      chk("os2_tirq", {31'b0, Tirq}, 32'h1);

      Pselx = 3'b001;
      Paddr = A_LOAD;
      Pwdata = 32'h77;
      Pwrite = 1'b1;
      Penable = 1'b0;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      #2 Hreset = 1'b1;
      #1;
      chk("midrst_prdata", Prdata, 32'h0);
      chk("midrst_tirq", {31'b0, Tirq}, 32'h0);
      idle();
      @(posedge Hclk);
      #3 Hreset = 1'b0;
      @(posedge Hclk);
      #1;
      apb_rd("midrst_ctrl", A_CTRL, 32'h0);
      apb_rd("midrst_load", A_LOAD, 32'h0);
      apb_rd("midrst_count", A_COUNT, 32'h0);
      apb_rd("midrst_status", A_STATUS, 32'h0);
      apb_rd("midrst_pre", A_PRE, 32'h0);

      // Auto-reload, tick on even edges E2,E4,..; expiry at E6,E12,..
      apb_wr(3'b001, A_LOAD, 32'h2);
      apb_wr(3'b001, A_PRE, 32'h1);
      apb_wr(3'b001, A_CTRL, 32'h3);
      apb_rd("ar_count2", A_COUNT, 32'h2);
      apb_rd("ar_count1", A_COUNT, 32'h1);
      apb_rd("ar_count0", A_COUNT, 32'h0);
      apb_rd("ar_reload", A_COUNT, 32'h2);
      apb_wr(3'b001, A_STATUS, 32'h1);
      apb_wr(3'b001, A_STATUS, 32'h1);
      apb_rd("ar_setwins", A_STATUS, 32'h1);
      apb_rd("ar_en_kept", A_CTRL, 32'h3);
      @(posedge Hclk);
      #1;
      apb_wr(3'b001, A_STATUS, 32'h1);
      apb_rd("ar_w1c_quiet", A_STATUS, 32'h0);
      @(posedge Hclk);
      #1;
      apb_wr(3'b001, A_CTRL, 32'h0);
      apb_rd("ar_stop_count", A_COUNT, 32'h0);
      apb_rd("ar_stop_status", A_STATUS, 32'h0);
      chk("ar_tirq_masked", {31'b0, Tirq}, 32'h0);

      @(posedge Hclk);
      #1;
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL leftover_reads: got %0d, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB slave peripheral directly downstream of the AHB-to-APB bridge; consumes Pselx/Penable/Pwrite/Paddr/Pwdata and returns Prdata.
- Contains a programmable down-counter timer with prescaler, auto-reload and a level interrupt.
- Zero-wait-state, because the bridge has no Pready. One instance is placed per Pselx bit.

Parameters:
- SEL_INDEX, 0: which bit of Pselx[2:0] selects this instance.
- CNT_W, 32: counter and LOAD register width (1..32); upper read bits are zero-filled.
- PRE_W, 16: prescaler register width (1..32).

Ports:
- Hclk  input  1  system clock; all state updates on its rising edge.
- Hreset  input  1  asynchronous, active-high reset.
- Pselx  input  3  one-hot APB select; this slave is selected when Pselx[SEL_INDEX]=1.
- Penable  input  1  APB access phase.
- Pwrite  input  1  1=write, 0=read.
- Paddr  input  32  APB address; only Paddr[4:2] is decoded.
- Pwdata  input  32  write data.
- Prdata  output  32  read data, registered.
- Tirq  output  1  timer interrupt, level, registered.

Behaviour:
- Reset (async, Hreset=1): Prdata=0, Tirq=0, CTRL=0, LOAD=0, PRESCALE=0, COUNT=0, prescale counter=0, EXPIRED=0. All outputs are driven from flops; no combinational path from input to output.
- Register map (Paddr[4:2]):
  - 0 CTRL, RW: bit0 EN, bit1 AUTO, bit2 IRQEN; other bits read 0.
  - 1 LOAD, RW.
  - 2 COUNT, RO; writes are ignored.
  - 3 STATUS: bit0 EXPIRED; write 1 to clear.
  - 4 PRESCALE, RW.
  - 5-7 unmapped: read 0, writes ignored.
- Setup phase (sel=1, Penable=0, Pwrite=0): Prdata is loaded with the addressed register value. Prdata is therefore stable throughout the access cycle, which is when the bridge samples it.
  - In all other cycles Prdata holds its value.
  - Any Paddr bits other than [4:2] are don't-care.
- Write commit: only in the access phase (sel=1, Penable=1, Pwrite=1), exactly once per transfer. A write in the setup phase has no effect.
- Tick generation:
  - While EN=1, the prescale counter increments each cycle.
  - When it equals PRESCALE, it wraps to 0 and asserts a one-cycle tick.
  - PRESCALE=0 gives a tick every cycle.
  - While EN=0, the prescale counter is held at 0.
- Count:
  - On a tick with COUNT>0: COUNT decrements by 1.
  - On a tick with COUNT==0: EXPIRED is set.
    - If AUTO=1, COUNT reloads from LOAD.
    - If AUTO=0, EN clears and COUNT stays 0.
- Enable edge: a CTRL write that changes EN from 0 to 1 copies LOAD into COUNT and zeroes the prescale counter in the same cycle. No tick is taken in that cycle.
- LOAD writes while running: take effect only at the next reload or re-enable.
- Tirq: registered EXPIRED & IRQEN, so it lags those bits by 1 cycle.
- Simultaneous events:
  - STATUS W1C in the same cycle as expiry: set wins, EXPIRED stays 1.
  - CTRL write with EN=0 in the same cycle as a tick: the write wins, no decrement.
  - CTRL write with AUTO=0 in the same cycle as a zero-tick: the new AUTO value is used.
- Reset mid-transfer: all state clears immediately. The next transfer after deassertion behaves normally.
- Width rules: LOAD/COUNT are truncated to CNT_W on write and zero-extended on read; PRESCALE likewise with PRE_W.

Decomposition:
- Shared package (apb_periph_pkg):
  - register offsets: ADDR_CTRL=3'd0, ADDR_LOAD=3'd1, ADDR_COUNT=3'd2, ADDR_STATUS=3'd3, ADDR_PRE=3'd4;
  - CTRL bit positions: EN=0, AUTO=1, IRQEN=2.
  - The package is reused by future APB peripherals.
- One natural sub-module, apb_slave_if: decodes sel/setup/access, produces wr_en, rd_en and the register index, and registers Prdata from a read-mux input.
- The timer core stays in apb_timer_slave.

Test Plan:
- Reset: assert Hreset mid-access -> Prdata=0, Tirq=0 asynchronously; read CTRL/LOAD/COUNT/STATUS/PRESCALE all return 0.
- Register R/W (SEL_INDEX=0):
  - write LOAD=0x0000_0010 and PRESCALE=0x3 -> reads return 0x10 and 0x3;
  - write COUNT=0xFFFF -> COUNT still reads 0;
  - unmapped offset 0x1C reads 0;
  - a transfer with Pselx=3'b010 leaves every register unchanged.
- One-shot: LOAD=3, PRESCALE=0, CTRL=0x5 (EN, IRQEN) -> COUNT reads 3,2,1,0 on successive ticks; EXPIRED=1 on the 4th tick after enable; EN reads 0; Tirq=1 one cycle after EXPIRED.
- Auto-reload with prescale: LOAD=2, PRESCALE=1, CTRL=0x3 -> COUNT decrements every 2 cycles and reloads to 2 after reaching 0; EXPIRED set every 6 cycles; EN stays 1.
- W1C and collision: write STATUS=1 in the same cycle as expiry -> EXPIRED remains 1; write STATUS=1 in a quiet cycle -> EXPIRED=0 and Tirq=0 one cycle later.
- Read timing: read COUNT while running with PRESCALE=0 -> Prdata equals the COUNT value at the setup-phase edge and holds through the access phase.
